rb_access_arbiter: RTL

Clocked arbiter that shares the single register-bank access port between several pipeline requesters: decode operand fetch, writeback and the issuer's PC/status port. Each requester uses the pipeline's two-phase (toggle) handshake. The arbiter synchronizes request toggles, grants one access at a time in round-robin order and drives the bank with a toggle trigger. It then returns read data and a toggle acknowledge to the winner. It sits between the asynchronous pipeline stages and the register bank, and replaces their direct `addrRB`/`triggerOutRB` wiring.

---
 rtl/rb_arb_pkg.sv | 35 +++
 rtl/rb_access_arbiter_toggle_sync.sv | 23 ++
 rtl/rb_access_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rb_arb_pkg.sv
// Shared types, default sizes and the round-robin pick used by the register-bank arbiter.
package rb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam int RB_ARB_NREQ = 3;
  localparam int RB_ARB_AW   = 4;
  localparam int RB_ARB_DW   = 32;

  // The pick function is sized for the largest supported requester count.
  localparam int RR_MAX   = 8;
  localparam int RR_IDX_W = 3;

  // First set bit of mask scanning ptr+1 .. ptr (mod n); returns ptr when mask is empty.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX-1:0]   mask,
    input logic [RR_IDX_W-1:0] ptr,
    input int                  n
  );
    logic [RR_IDX_W-1:0] win;
    int                  idx;
    win = ptr;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(ptr) + k) % n;
      if (mask[idx[RR_IDX_W-1:0]]) win = RR_IDX_W'(idx);
    end
    return win;
  endfunction

endpackage

// File: rtl/rb_access_arbiter_toggle_sync.sv
// Multi-flop synchronizer for a two-phase toggle signal; clears to 0 on reset.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic toggle_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rb_access_arbiter.sv
// Round-robin arbiter sharing one register-bank port among toggle-handshake requesters.
// Optional build macro RB_ARB_WRITE_PRIO_EN: pending writes win over pending reads.
module rb_access_arbiter
  import rb_arb_pkg::*;
#(
  parameter int NREQ        = RB_ARB_NREQ,
  parameter int AW          = RB_ARB_AW,
  parameter int DW          = RB_ARB_DW,
  parameter int SYNC_STAGES = 2,
  localparam int GW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_toggle,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    ack_toggle,
  output logic [DW-1:0]      rdata,
  output logic [GW-1:0]      grant_id,
  output logic [AW-1:0]      rb_addr,
  output logic               rb_we,
  output logic [DW-1:0]      rb_wdata,
  output logic               rb_trigger,
  input  logic               rb_ack,
  input  logic [DW-1:0]      rb_rdata
);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [GW-1:0]     grant_id_q, grant_id_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic [AW-1:0]     rb_addr_q, rb_addr_d;
  logic              rb_we_q, rb_we_d;
  logic [DW-1:0]     rb_wdata_q, rb_wdata_d;
  logic              rb_trigger_q, rb_trigger_d;

  logic [NREQ-1:0]   req_sync;
  logic              rb_ack_sync;
  logic [NREQ-1:0]   pending;
  logic [RR_MAX-1:0] arb_mask;
  logic [GW-1:0]     pick;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_sync
      toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
        .clk      (clk),
        .reset    (reset),
        .toggle_i (req_toggle[gi]),
        .sync_o   (req_sync[gi])
      );
    end
  endgenerate

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk      (clk),
    .reset    (reset),
    .toggle_i (rb_ack),
    .sync_o   (rb_ack_sync)
  );

  // A requester is owed an access while its synchronized toggle differs from its ack.
  assign pending = req_sync ^ ack_q;

  always_comb begin
    arb_mask             = '0;
    arb_mask[NREQ-1:0]   = pending;
`ifdef RB_ARB_WRITE_PRIO_EN
    if (|(pending & req_we)) arb_mask[NREQ-1:0] = pending & req_we;
`endif
    pick = GW'(rr_pick(arb_mask, RR_IDX_W'(last_grant_q), NREQ));
  end

  always_comb begin
    state_d      = state_q;
    ack_d        = ack_q;
    rdata_d      = rdata_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    rb_addr_d    = rb_addr_q;
    rb_we_d      = rb_we_q;
    rb_wdata_d   = rb_wdata_q;
    rb_trigger_d = rb_trigger_q;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          grant_id_d = pick;
          rb_addr_d  = req_addr[pick*AW +: AW];
          rb_we_d    = req_we[pick];
          rb_wdata_d = req_wdata[pick*DW +: DW];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        rb_trigger_d = ~rb_trigger_q;
        state_d      = WAIT;
      end
      WAIT: begin
        // Bank is done once its synchronized ack has caught up with our trigger.
        if (rb_ack_sync == rb_trigger_q) begin
          if (!rb_we_q) rdata_d = rb_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        ack_d[grant_id_q] = ~ack_q[grant_id_q];
        last_grant_d      = grant_id_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ack_q        <= '0;
      rdata_q      <= '0;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NREQ - 1);
      rb_addr_q    <= '0;
      rb_we_q      <= 1'b0;
      rb_wdata_q   <= '0;
      rb_trigger_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      rb_addr_q    <= rb_addr_d;
      rb_we_q      <= rb_we_d;
      rb_wdata_q   <= rb_wdata_d;
      rb_trigger_q <= rb_trigger_d;
    end
  end

  assign ack_toggle = ack_q;
  assign rdata      = rdata_q;
  assign grant_id   = grant_id_q;
  assign rb_addr    = rb_addr_q;
  assign rb_we      = rb_we_q;
  assign rb_wdata   = rb_wdata_q;
  assign rb_trigger = rb_trigger_q;

endmodule
